div11_seq_ctrl: RTL and testbench

Sequential controller that divides an unsigned WIDTH-bit dividend by the constant 11. It steps a radix-4 (2 bits per cycle) quotient/residue chunk lookup across the dividend, MSB first, and sequences the operand and result registers around that lookup. It sits between a valid/ready producer and consumer in the constant-division datapath. It time-shares one small combinational chunk stage instead of using a fully unrolled array.

---
 rtl/div11_seq_ctrl.sv | 124 ++++++++++++
 tb/tb_div11_seq_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/div11_seq_ctrl.sv
// Sequential divide-by-11 controller: one radix-4 quotient/residue chunk per cycle,
// MSB first, with valid/ready handshakes on the operand and result sides.
module div11_seq_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [3:0]       remainder,
    output logic             busy
);

    localparam int unsigned   STEPS  = WIDTH / 2;
    localparam int unsigned   KW     = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(STEPS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [3:0]       rem_q, rem_d;
    logic [KW-1:0]    k_q, k_d;

    logic [5:0]       w;
    logic [1:0]       chunk_q;
    logic [3:0]       chunk_r;

    // Residue stays <= 10, so w <= 43 and the table only needs four quotient bands.
    always_comb begin
        w       = {rem_q, sh_q[WIDTH-1 -: 2]};
        chunk_q = 2'd0;
        chunk_r = 4'd0;
        case (w) inside
            [6'd0:6'd10]: begin
                chunk_q = 2'd0;
                chunk_r = w[3:0];
            end
            [6'd11:6'd21]: begin
                chunk_q = 2'd1;
                chunk_r = 4'(w - 6'd11);
            end
            [6'd22:6'd32]: begin
                chunk_q = 2'd2;
                chunk_r = 4'(w - 6'd22);
            end
            [6'd33:6'd43]: begin
                chunk_q = 2'd3;
                chunk_r = 4'(w - 6'd33);
            end
            default: begin
                chunk_q = 2'd0;
                chunk_r = 4'd0;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        k_d     = k_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sh_d    = dividend;
                    rem_d   = '0;
                    quot_d  = '0;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sh_d   = sh_q << 2;
                rem_d  = chunk_r;
                quot_d = (quot_q << 2) | WIDTH'(chunk_q);
                k_d    = k_q + KW'(1);
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sh_q    <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            k_q     <= k_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign quotient  = quot_q;
    assign remainder = rem_q;

endmodule

// File: tb/tb_div11_seq_ctrl.sv
// Self-checking bench for div11_seq_ctrl: directed vector table, handshake corner
// sequences and a randomized stall regression against a plain-arithmetic model.
module tb_div11_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quotient;
    logic [3:0]  remainder;
    logic        busy;

    int total = 0;
    int bad   = 0;

    div11_seq_ctrl #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [31:0] q;
        logic [3:0]  r;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", nm, act, act, exp, exp);
        end
    endtask

    // Called at a negedge; leaves the bench at a negedge in IDLE with the result taken.
    task automatic run_vec(input logic [31:0] d, input logic [31:0] eq, input logic [3:0] er,
                           input string nm);
        int lat;
        lat = 0;
        while (!in_ready && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, " ready"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        dividend = d;
        @(negedge clk);
        in_valid = 1'b0;
        chk({nm, " busy"}, {31'd0, busy}, 32'd1);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, " latency"}, lat, 32'd16);
        chk({nm, " q"}, quotient, eq);
        chk({nm, " r"}, {28'd0, remainder}, {28'd0, er});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({nm, " drop valid"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] q_hold;
        logic [3:0]  r_hold;
        logic        seen_valid;
        int          lat;
        int          n_rand;
        int          acc;
        int          got;
        logic [35:0] expq[$];

        vecs[0] = '{32'hFFFF_FFFF, 32'd390451572, 4'd3};
        vecs[1] = '{32'h8000_0000, 32'd195225786, 4'd2};
        vecs[2] = '{32'd0,         32'd0,         4'd0};
        vecs[3] = '{32'd10,        32'd0,         4'd10};
        vecs[4] = '{32'd11,        32'd1,         4'd0};
        vecs[5] = '{32'd121,       32'd11,        4'd0};
        vecs[6] = '{32'd1000,      32'd90,        4'd10};
        vecs[7] = '{32'hFFFF_FFFE, 32'd390451572, 4'd2};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        dividend  = '0;
        out_ready = 1'b0;
        @(negedge clk);
        chk("reset in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset quotient", quotient, 32'd0);
        chk("reset remainder", {28'd0, remainder}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i].d, vecs[i].q, vecs[i].r, $sformatf("vec%0d", i));
        end

        // Backpressure: result held for 5 cycles while a new dividend waits.
        in_valid = 1'b1;
        dividend = 32'd5000;
        @(negedge clk);
        dividend = 32'd22;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("bp latency", lat, 32'd16);
        chk("bp first q", quotient, 32'd454);
        chk("bp first r", {28'd0, remainder}, 32'd6);
        q_hold = quotient;
        r_hold = remainder;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp hold valid", {31'd0, out_valid}, 32'd1);
            chk("bp hold q", quotient, q_hold);
            chk("bp hold r", {28'd0, remainder}, {28'd0, r_hold});
            chk("bp hold in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp idle in_ready", {31'd0, in_ready}, 32'd1);
        chk("bp idle out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp accepted", {31'd0, busy}, 32'd1);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("bp second latency", lat, 32'd16);
        chk("bp second q", quotient, 32'd2);
        chk("bp second r", {28'd0, remainder}, 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset in the middle of a run.
        in_valid = 1'b1;
        dividend = 32'hFFFF_FFFF;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst busy", {31'd0, busy}, 32'd0);
        chk("midrst out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst quotient", quotient, 32'd0);
        chk("midrst remainder", {28'd0, remainder}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            seen_valid = seen_valid | out_valid;
        end
        chk("midrst no valid", {31'd0, seen_valid}, 32'd0);
        chk("midrst idle ready", {31'd0, in_ready}, 32'd1);
        run_vec(32'd1000, 32'd90, 4'd10, "post rst");

        // Randomized regression with stalls on both sides.
        n_rand = 2500;
        acc    = 0;
        got    = 0;
        for (int cyc = 0; cyc < 90000 && got < n_rand; cyc++) begin
            logic        nv;
            logic        nr;
            logic [31:0] nd;
            logic [35:0] e;
            @(negedge clk);
            nv = (acc < n_rand) && ($urandom_range(3) != 0);
            nr = ($urandom_range(3) != 0);
            case ($urandom_range(7))
                0:       nd = 32'hFFFF_FFFF;
                1:       nd = 32'($urandom_range(40));
                default: nd = $urandom;
            endcase
            if (out_valid && nr) begin
                if (expq.size() == 0) begin
                    chk("rand extra result", 32'd1, 32'd0);
                end else begin
                    e = expq.pop_front();
                    chk("rand q", quotient, e[35:4]);
                    chk("rand r", {28'd0, remainder}, {28'd0, e[3:0]});
                    chk("rand r range", {31'd0, (remainder <= 4'd10)}, 32'd1);
                end
                got++;
            end
            if (in_ready && nv) begin
                expq.push_back({nd / 32'd11, 4'(nd % 32'd11)});
                acc++;
            end
            in_valid  = nv;
            dividend  = nd;
            out_ready = nr;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("rand result count", got, n_rand);
        chk("rand accept count", acc, n_rand);
        chk("rand queue empty", expq.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
